// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit delay line of DEPTH stages with per-stage valid, stall, flush and occupancy count
module dff_pipe #(
  parameter int              WIDTH   = 4,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int             OW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  input  logic             in_vld,
  output logic [WIDTH-1:0] Q,
  output logic             q_vld,
  output logic [OW-1:0]    occ,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OW-1:0]    r_occ;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= RST_VAL;
      r_vld <= '0;
      r_occ <= '0;
    end else if (en) begin
      r_data[0] <= D;
      r_vld[0]  <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        r_data[i] <= r_data[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      // one word enters and the oldest leaves on every shift, so occ stays within 0..DEPTH
      r_occ <= r_occ + OW'(in_vld) - OW'(r_vld[DEPTH-1]);
    end
  end
  assign Q     = r_data[DEPTH-1];
  assign q_vld = r_vld[DEPTH-1];
  assign occ   = r_occ;
  assign full  = r_occ == OW'(DEPTH);
  assign empty = r_occ == '0;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: drives a DEPTH=1 and a DEPTH=3 pipe with the same stimulus and checks both
module tb_dff_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, clr = 1'b0, in_vld = 1'b0;
  logic [3:0] d = '0;
  logic [3:0] q1, q3;
  logic       v1, v3, f1, f3, e1, e3;
  logic       o1;
  logic [1:0] o3;
  int compared = 0, mismatched = 0;
  logic [3:0] hw[$];
  bit         hv[$];

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(4), .DEPTH(1), .RST_VAL(4'h0)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d), .in_vld(in_vld),
    .Q(q1), .q_vld(v1), .occ(o1), .full(f1), .empty(e1));
  dff_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'hA)) u3 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .D(d), .in_vld(in_vld),
    .Q(q3), .q_vld(v3), .occ(o3), .full(f3), .empty(e3));

  // Reference: history of words accepted since the last clear; output is the one DEPTH pushes ago
  function automatic logic [3:0] exp_q(int dep, logic [3:0] rv);
    return hw.size() >= dep ? hw[hw.size()-dep] : rv;
  endfunction
  function automatic logic exp_v(int dep);
    return hv.size() >= dep ? hv[hv.size()-dep] : 1'b0;
  endfunction
  function automatic int exp_occ(int dep);
    int n = 0;
    for (int k = 0; k < dep && k < hv.size(); k++) n += int'(hv[hv.size()-1-k]);
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d1_q", 32'(q1), 32'(exp_q(1, 4'h0)));
    chk("d1_vld", 32'(v1), 32'(exp_v(1)));
    chk("d1_occ", 32'(o1), 32'(exp_occ(1)));
    chk("d1_full", 32'(f1), 32'(exp_occ(1) == 1));
    chk("d1_empty", 32'(e1), 32'(exp_occ(1) == 0));
    chk("d3_q", 32'(q3), 32'(exp_q(3, 4'hA)));
    chk("d3_vld", 32'(v3), 32'(exp_v(3)));
    chk("d3_occ", 32'(o3), 32'(exp_occ(3)));
    chk("d3_full", 32'(f3), 32'(exp_occ(3) == 3));
    chk("d3_empty", 32'(e3), 32'(exp_occ(3) == 0));
  endtask

  task automatic step(logic e, logic c, logic [3:0] dv, logic v);
    en = e; clr = c; d = dv; in_vld = v;
    @(posedge clk);
    if (c) begin
      hw.delete(); hv.delete();
    end else if (e) begin
      hw.push_back(dv); hv.push_back(v);
      if (hw.size() > 8) begin
        void'(hw.pop_front()); void'(hv.pop_front());
      end
    end
    #1 check_all();
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    hw.delete(); hv.delete();
    #1 check_all();
    rst = 1'b0;
    #1 check_all();
  endtask

  initial begin
    async_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 4'($urandom), 1'($urandom));
    step(1'b1, 1'b1, 4'h0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 4'(i), 1'b1);
    step(1'b0, 1'b0, 4'hF, 1'b1);
    step(1'b0, 1'b0, 4'hE, 1'b0);
    step(1'b1, 1'b0, 4'h5, 1'b1);
    step(1'b1, 1'b0, 4'h6, 1'b1);
    step(1'b1, 1'b0, 4'h7, 1'b1);
    step(1'b1, 1'b1, 4'h8, 1'b1);
    step(1'b1, 1'b0, 4'h3, 1'b1);
    step(1'b1, 1'b0, 4'h4, 1'b0);
    async_reset();
    step(1'b1, 1'b0, 4'h9, 1'b1);
    step(1'b1, 1'b0, 4'($urandom), 1'b1);
    step(1'b1, 1'b0, 4'($urandom), 1'b1);
    step(1'b1, 1'b0, 4'($urandom), 1'b0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 4'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
